// File: rtl/mips_pkg.sv
// Shared instruction-memory definitions: boot-loader state encoding and memory geometry.
package mips_pkg;

    localparam int INSTR_ADDRWIDTH  = 18;
    localparam int BOOT_VECTOR_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_PC,
        ST_HDR_LEN,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Boot loader bus: host byte stream and control in, instruction memory write port and status out.
interface imem_loader_if
    import mips_pkg::*;
#(
    parameter int ADDRWIDTH = INSTR_ADDRWIDTH
) ();

    logic                 start;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 mem_write;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [31:0]          mem_data;
    logic                 hold;
    logic                 done;
    logic                 error;

    // master: the loader itself; slave: host link plus memory/core side
    modport master (
        input  start, in_valid, in_data,
        output in_ready, mem_write, mem_addr, mem_data, hold, done, error
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, mem_write, mem_addr, mem_data, hold, done, error
    );

endinterface

// File: rtl/byte_to_word.sv
// Little-endian byte-to-word assembler: word_valid pulses combinationally with the 4th accepted byte.
module byte_to_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] sh;

    // Bytes shift in from the top so byte 0 ends up in the low lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sh  <= '0;
        end else if (byte_valid) begin
            cnt <= cnt + 2'd1;
            sh  <= {byte_data, sh[23:8]};
        end
    end

    assign word       = {byte_data, sh};
    assign word_valid = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header (entry PC, count), program image, optional checksum.
// Optional CHECK state enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDRWIDTH = INSTR_ADDRWIDTH,
    parameter int MAXWORDS  = (2 ** ADDRWIDTH) - 1
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.master bus
);

    localparam logic [31:0]          MAX_W     = 32'(MAXWORDS);
    localparam logic [ADDRWIDTH:0]   MEM_WORDS = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [ADDRWIDTH-1:0] BOOT_ADDR = ADDRWIDTH'(BOOT_VECTOR_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    loader_state_e        state, state_n;
    logic [ADDRWIDTH-1:0] base_q, base_n;
    logic [ADDRWIDTH-1:0] waddr_q, waddr_n;
    logic [ADDRWIDTH-1:0] left_q, left_n;
    logic                 mem_write_q, mem_write_n;
    logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_n;
    logic [31:0]          mem_data_q, mem_data_n;
    logic                 hold_q, hold_n;
    logic                 done_q, done_n;
    logic                 error_q, error_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]          sum_q, sum_n;
`endif

    logic                 in_ready;
    logic                 accept;
    logic [31:0]          word;
    logic                 word_valid;
    logic [ADDRWIDTH:0]   end_w;

    assign in_ready = (state == ST_HDR_PC) || (state == ST_HDR_LEN) ||
                      (state == ST_DATA)   || (state == ST_CHECK);
    assign accept   = bus.in_valid && in_ready;

    byte_to_word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept),
        .byte_data  (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // One past the last image word; only meaningful once COUNT <= MAXWORDS.
    assign end_w = {1'b0, base_q} + {1'b0, word[ADDRWIDTH-1:0]};

    always_comb begin
        state_n     = state;
        base_n      = base_q;
        waddr_n     = waddr_q;
        left_n      = left_q;
        mem_write_n = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_data_n  = mem_data_q;
        hold_n      = hold_q;
        done_n      = done_q;
        error_n     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_n       = sum_q;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start) state_n = ST_HDR_PC;
            end
            ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    state_n = ST_HDR_PC;
                    hold_n  = 1'b1;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                end
            end
            ST_HDR_PC: begin
                if (word_valid) begin
                    // Word 0 holds the entry PC, so the image may not start there.
                    if (word[1:0] != 2'b00 || word[ADDRWIDTH+1:2] == '0) begin
                        state_n = ST_ERROR;
                        error_n = 1'b1;
                    end else begin
                        state_n     = ST_HDR_LEN;
                        base_n      = word[ADDRWIDTH+1:2];
                        mem_write_n = 1'b1;
                        mem_addr_n  = BOOT_ADDR;
                        mem_data_n  = word;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_n       = word;
`endif
                    end
                end
            end
            ST_HDR_LEN: begin
                if (word_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_n = sum_q + word;
`endif
                    if (word > MAX_W || end_w > MEM_WORDS) begin
                        state_n = ST_ERROR;
                        error_n = 1'b1;
                    end else if (word == '0) begin
                        if (CHK) begin
                            state_n = ST_CHECK;
                        end else begin
                            state_n = ST_DONE;
                            hold_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        state_n = ST_DATA;
                        waddr_n = base_q;
                        left_n  = word[ADDRWIDTH-1:0];
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_write_n = 1'b1;
                    mem_addr_n  = waddr_q;
                    mem_data_n  = word;
                    waddr_n     = waddr_q + 1'b1;
                    left_n      = left_q - 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_n       = sum_q + word;
`endif
                    if (left_q == ADDRWIDTH'(1)) begin
                        if (CHK) begin
                            state_n = ST_CHECK;
                        end else begin
                            state_n = ST_DONE;
                            hold_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (word_valid) begin
                    if (word == sum_q) begin
                        state_n = ST_DONE;
                        hold_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_ERROR;
                        error_n = 1'b1;
                    end
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            waddr_q     <= '0;
            left_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state       <= state_n;
            base_q      <= base_n;
            waddr_q     <= waddr_n;
            left_q      <= left_n;
            mem_write_q <= mem_write_n;
            mem_addr_q  <= mem_addr_n;
            mem_data_q  <= mem_data_n;
            hold_q      <= hold_n;
            done_q      <= done_n;
            error_q     <= error_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_n;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.hold      = hold_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model of the boot format.
module tb_imem_loader;

    localparam int AW = 18;
    localparam longint NWORDS = 64'd1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDRWIDTH(AW)) bus ();
    imem_loader #(.ADDRWIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit gaps   = 1'b0;

    logic [AW+31:0] wr_q[$];
    logic [AW+31:0] exp_q[$];
    logic [31:0]    img[$];
    logic [31:0]    st_q[$];
    bit             exp_done, exp_err;

    // Every write seen on the memory port, as {addr, data}
    always @(negedge clk) if (bus.mem_write === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_data});

    // Reference: expected writes, final status and the byte stream the host actually sends
    task automatic model(input logic [31:0] pc, input logic [31:0] cnt, input bit sum_ok);
        longint base;
        logic [31:0] sum;
        exp_q.delete(); st_q.delete();
        exp_done = 1'b0; exp_err = 1'b0;
        st_q.push_back(pc);
        base = longint'(pc >> 2) % NWORDS;
        if (pc[1:0] != 2'b00 || base == 0) begin exp_err = 1'b1; return; end
        exp_q.push_back({AW'(0), pc});
        st_q.push_back(cnt);
        if (longint'(cnt) > NWORDS - 1 || base + longint'(cnt) > NWORDS) begin exp_err = 1'b1; return; end
        sum = pc + cnt;
        for (int i = 0; i < int'(cnt); i++) begin
            exp_q.push_back({AW'(base + i), img[i]});
            st_q.push_back(img[i]);
            sum = sum + img[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        st_q.push_back(sum_ok ? sum : sum + 32'd1);
        exp_done = sum_ok;
        exp_err  = !sum_ok;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic gen_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        if (w == 20) begin
            checks++; errors++;
            $display("FAIL send_byte: in_ready stuck at %b, expected 1 within 20 cycles", bus.in_ready);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic run_image(input logic [31:0] pc, input logic [31:0] cnt, input bit sum_ok, input string name);
        bit exp_w;
        bit ok;
        model(pc, cnt, sum_ok);
        wr_q.delete();
        pulse_start();
        for (int j = 0; j < st_q.size(); j++) begin
            send_word(st_q[j]);
            exp_w = (j == 0 && exp_q.size() > 0) || (j >= 2 && j < 2 + exp_q.size() - 1);
            checks++;
            if (bus.mem_write !== exp_w) begin
                errors++;
                $display("FAIL %s write_latency word%0d: mem_write=%b expected %b", name, j, bus.mem_write, exp_w);
            end
        end
        checks++;
        if ({bus.done, bus.error, bus.hold} !== {exp_done, exp_err, !exp_done}) begin
            errors++;
            $display("FAIL %s status: done/error/hold=%b%b%b expected %b%b%b", name,
                     bus.done, bus.error, bus.hold, exp_done, exp_err, !exp_done);
        end
        repeat (3) @(negedge clk);
        checks++;
        ok = (wr_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (wr_q[i] !== exp_q[i]) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL %s writes: got %0d writes (first %0h) expected %0d (first %0h)", name,
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_end: got %b expected 0", name, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.mem_write, bus.hold, bus.done, bus.error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/wr/hold/done/err=%b%b%b%b%b expected 00100",
                     bus.in_ready, bus.mem_write, bus.hold, bus.done, bus.error);
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0h data=%0h expected 0 0", bus.mem_addr, bus.mem_data);
        end
        wr_q.delete();
        repeat (6) begin bus.in_data = 8'($urandom); @(negedge clk); end
        bus.in_valid = 1'b0;
        checks++;
        if (wr_q.size() != 0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: writes=%0d in_ready=%b expected 0 0", wr_q.size(), bus.in_ready);
        end
    endtask

    task automatic test_basic();
        gaps = 1'b0;
        img.delete(); img.push_back(32'hAAAA_0001); img.push_back(32'hBBBB_0002); img.push_back(32'hCCCC_0003);
        run_image(32'h0000_0100, 32'd3, 1'b1, "basic");
        checks++;
        if (wr_q.size() != 4 || wr_q[1] !== {AW'('h40), 32'hAAAA_0001} || wr_q[3] !== {AW'('h42), 32'hCCCC_0003}) begin
            errors++;
            $display("FAIL basic_addr: got %0d writes, second=%0h expected 4 writes, second=%0h",
                     wr_q.size(), (wr_q.size() > 1) ? wr_q[1] : '0, {AW'('h40), 32'hAAAA_0001});
        end
    endtask

    task automatic test_bad_header();
        gaps = 1'b1;
        gen_img(3);
        run_image(32'h0000_0102, 32'd3, 1'b1, "misaligned_pc");
        run_image(32'h0000_0000, 32'd3, 1'b1, "pc_zero");
        run_image(32'h000F_FFF8, 32'd3, 1'b1, "overflow");
        run_image(32'h0000_0100, 32'h0004_0000, 1'b1, "count_gt_max");
        run_image(32'h000F_FFF4, 32'd3, 1'b1, "exact_fit");
        run_image(32'h0000_0100, 32'd3, 1'b1, "restart_ok");
    endtask

    task automatic test_zero_count();
        gaps = 1'b0;
        img.delete();
        run_image(32'h0000_0200, 32'd0, 1'b1, "zero_count");
    endtask

    task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        gaps = 1'b1;
        gen_img(4);
        run_image(32'h0000_0400, 32'd4, 1'b1, "sum_good");
        run_image(32'h0000_0400, 32'd4, 1'b0, "sum_bad");
`endif
    endtask

    task automatic test_random();
        longint base;
        logic [31:0] pc;
        for (int it = 0; it < 25; it++) begin
            gaps = 1'($urandom);
            gen_img($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) base = NWORDS - longint'($urandom_range(1, 8));
            else                           base = longint'($urandom_range(1, 4000));
            pc = ($urandom & 32'hFFF0_0000) | 32'(base << 2);
            if ($urandom_range(0, 7) == 0) pc[0] = 1'b1;
            run_image(pc, 32'(img.size()), $urandom_range(0, 3) != 0, "random");
        end
    endtask

    task automatic test_rst_mid();
        gaps = 1'b1;
        gen_img(6);
        model(32'h0000_0800, 32'd6, 1'b1);
        wr_q.delete();
        pulse_start();
        for (int j = 0; j < 5; j++) send_word(st_q[j]);
        send_byte(8'h12); send_byte(8'h34);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({bus.in_ready, bus.mem_write, bus.hold, bus.done, bus.error} !== 5'b00100 ||
            bus.mem_addr !== '0 || bus.mem_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: rdy/wr/hold/done/err=%b%b%b%b%b addr=%0h data=%0h expected 00100 0 0",
                     bus.in_ready, bus.mem_write, bus.hold, bus.done, bus.error, bus.mem_addr, bus.mem_data);
        end
        checks++;
        if (wr_q.size() != 4 || wr_q[3] !== exp_q[3]) begin
            errors++;
            $display("FAIL rst_mid_prior: got %0d writes expected 4", wr_q.size());
        end
        repeat (8) begin bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom); @(negedge clk); end
        bus.in_valid = 1'b0;
        checks++;
        if (wr_q.size() != 4 || bus.in_ready !== 1'b0 || bus.hold !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet: writes=%0d in_ready=%b hold=%b expected 4 0 1", wr_q.size(), bus.in_ready, bus.hold);
        end
        gen_img(2);
        run_image(32'h0000_0900, 32'd2, 1'b1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_zero_count();
        test_checksum();
        test_random();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
